// File: rtl/fp_mult_significand_engine.sv
// fp_mult_significand_engine
// Multi-cycle significand multiplier for an 8-bit float format.
// Operand format: sign[7], exponent[6:3] with bias 7, fraction[2:0] with hidden 1.
// The 4x4 significand product is built by shift-add, one bit of sb per cycle.
// Normalization, guard/sticky and exponent range flags are registered in NORM.
// The result is then held in DONE until the downstream stage takes it.
module fp_mult_significand_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       norm_s,
  output logic [3:0] norm_m,
  output logic [3:0] norm_e,
  output logic       guard,
  output logic       sticky,
  output logic       zero,
  output logic       ovf,
  output logic       unf
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  typedef struct packed {
    logic       s;
    logic [3:0] m;
    logic [3:0] e;
    logic       g;
    logic       st;
    logic       z;
    logic       o;
    logic       u;
  } res_t;

  state_t      state, state_nx;
  logic [7:0]  a_q, b_q;
  logic [7:0]  acc;
  logic [1:0]  cnt;
  res_t        res_q, res_d;

  logic [3:0]  sa, sb;
  logic        op_zero;
  logic [7:0]  pp;
  logic signed [5:0] e6;

  assign sa      = {1'b1, a_q[2:0]};
  assign sb      = {1'b1, b_q[2:0]};
  assign op_zero = (a_q[6:3] == 4'd0) || (b_q[6:3] == 4'd0);
  assign pp      = sb[cnt] ? ({4'd0, sa} << cnt) : 8'd0;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign norm_s = res_q.s;
  assign norm_m = res_q.m;
  assign norm_e = res_q.e;
  assign guard  = res_q.g;
  assign sticky = res_q.st;
  assign zero   = res_q.z;
  assign ovf    = res_q.o;
  assign unf    = res_q.u;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. The zero check looks at the latched operands, so a
  // zero operand bails out of MUL on its first cycle without accumulating.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)                         state_nx = MUL;
      MUL:  if (op_zero || cnt == 2'd3)           state_nx = NORM;
      NORM:                                       state_nx = DONE;
      DONE: if (out_ready)                        state_nx = IDLE;
      default:                                    state_nx = IDLE;
    endcase
  end

  // Normalize the product and classify the exponent
  always_comb begin
    res_d   = '0;
    res_d.s = a_q[7] ^ b_q[7];
    e6 = $signed({2'b00, a_q[6:3]}) + $signed({2'b00, b_q[6:3]})
       - 6'sd7 + $signed({5'd0, acc[7]});
    if (op_zero) begin
      res_d.z = 1'b1;
    end else begin
      if (acc[7]) begin
        res_d.m  = acc[7:4];
        res_d.g  = acc[3];
        res_d.st = |acc[2:0];
      end else begin
        res_d.m  = acc[6:3];
        res_d.g  = acc[2];
        res_d.st = |acc[1:0];
      end
      if (e6 > 6'sd15) begin
        // Overflow saturates the exponent but leaves the significand intact
        res_d.o = 1'b1;
        res_d.e = 4'hF;
      end else if (e6 < 6'sd1) begin
        res_d.u  = 1'b1;
        res_d.e  = 4'd0;
        res_d.m  = 4'd0;
        res_d.g  = 1'b0;
        res_d.st = 1'b0;
      end else begin
        res_d.e = e6[3:0];
      end
    end
  end

  // Operand latch, shift-add datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= op_a;
          b_q <= op_b;
          acc <= '0;
          cnt <= '0;
        end
        MUL: if (!op_zero) begin
          acc <= acc + pp;
          cnt <= cnt + 2'd1;
        end
        NORM: res_q <= res_d;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_significand_engine.sv
// Scoreboard bench for fp_mult_significand_engine: expected results are
// queued when operands are driven and compared when out_valid appears.
module tb_fp_mult_significand_engine;

  typedef struct packed {
    logic       s;
    logic [3:0] m;
    logic [3:0] e;
    logic       g;
    logic       st;
    logic       z;
    logic       o;
    logic       u;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a, op_b;
  logic       out_valid;
  logic       out_ready;
  logic       norm_s;
  logic [3:0] norm_m, norm_e;
  logic       guard, sticky, zero, ovf, unf;

  int   total = 0;
  int   bad   = 0;
  res_t sb_q[$];

  fp_mult_significand_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .norm_s(norm_s), .norm_m(norm_m), .norm_e(norm_e),
    .guard(guard), .sticky(sticky), .zero(zero), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t got_res();
    return {norm_s, norm_m, norm_e, guard, sticky, zero, ovf, unf};
  endfunction

  // Reference: integer multiply, then normalize/classify
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int   p, e;
    r   = '0;
    r.s = a[7] ^ b[7];
    if (a[6:3] == 4'd0 || b[6:3] == 4'd0) begin
      r.z = 1'b1;
      return r;
    end
    p = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
    e = int'(a[6:3]) + int'(b[6:3]) - 7 + ((p >= 128) ? 1 : 0);
    if (p >= 128) begin
      r.m  = 4'(p / 16);
      r.g  = 1'((p / 8) % 2);
      r.st = (p % 8) != 0;
    end else begin
      r.m  = 4'(p / 8);
      r.g  = 1'((p / 4) % 2);
      r.st = (p % 4) != 0;
    end
    if (e > 15) begin
      r.o = 1'b1;
      r.e = 4'hF;
    end else if (e < 1) begin
      r.u = 1'b1; r.e = 4'd0; r.m = 4'd0; r.g = 1'b0; r.st = 1'b0;
    end else begin
      r.e = 4'(e);
    end
    return r;
  endfunction

  // Drive one operand pair, check latency, result, hold behaviour and retire
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input res_t exp, input int hold);
    res_t e;
    int   n, lat;
    sb_q.push_back(exp);
    lat = ((a[6:3] == 4'd0) || (b[6:3] == 4'd0)) ? 2 : 5;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op_a = a; op_b = b;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk); op_a = 8'($urandom);
    end
    chk("latency", 32'(n), 32'(lat));
    e = sb_q.pop_front();
    chk("result", 32'(got_res()), 32'(e));
    repeat (hold) begin
      @(posedge clk);
      #1 op_a = ~op_a; op_b = ~op_b;
      @(negedge clk);
      chk("hold_result", 32'(got_res()), 32'(e));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    // Offer a new pair on the retire edge; it must not be taken there
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("retire_in_ready", 32'(in_ready), 32'd1);
    chk("retire_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int   n;
    logic [7:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(got_res()), 32'd0);
    rst_n = 1'b1;

    do_op(8'h3C, 8'h3C, '{s:1'b0, m:4'b1001, e:4'd8, g:1'b0, st:1'b0, z:1'b0, o:1'b0, u:1'b0}, 0);
    do_op(8'hB8, 8'h38, '{s:1'b1, m:4'b1000, e:4'd7, g:1'b0, st:1'b0, z:1'b0, o:1'b0, u:1'b0}, 0);
    do_op(8'h00, 8'h3C, '{s:1'b0, m:4'd0, e:4'd0, g:1'b0, st:1'b0, z:1'b1, o:1'b0, u:1'b0}, 0);
    do_op(8'h7F, 8'h7F, '{s:1'b0, m:4'b1110, e:4'hF, g:1'b0, st:1'b1, z:1'b0, o:1'b1, u:1'b0}, 0);
    do_op(8'h08, 8'h88, '{s:1'b1, m:4'd0, e:4'd0, g:1'b0, st:1'b0, z:1'b0, o:1'b0, u:1'b1}, 0);
    do_op(8'hBC, 8'h3A, model(8'hBC, 8'h3A), 3);

    // Reset while MUL is at count=2
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'h3C; op_b = 8'h3C;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_stale_valid", 32'(n), 32'd0);

    do_op(8'h4B, 8'h35, model(8'h4B, 8'h35), 1);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 3) ra[6:3] = 4'd0;
      do_op(ra, rb, model(ra, rb), i % 3);
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
